// File: rtl/mem_stage.sv
// mem_stage: memory stage between EX/MEM and MEM/WB.
// Turns a latched load/store into one data-bus request (valid/addr_ok/data_ok),
// waits for completion, aligns/extends load data and emits one registered
// writeback record per instruction. stall_req is high while an access is in flight.
// Optional feature: define MEM_MISALIGN_CHECK_EN to trap misaligned accesses
// (no bus request, out_misalign=1). Without it out_misalign is always 0.
module mem_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [XLEN-1:0] in_result,
    input  logic [4:0]      in_rd,
    input  logic            in_wen,
    output logic            dreq_valid,
    output logic [XLEN-1:0] dreq_addr,
    output logic [1:0]      dreq_size,
    output logic [7:0]      dreq_strobe,
    output logic [XLEN-1:0] dreq_data,
    input  logic            dresp_addr_ok,
    input  logic            dresp_data_ok,
    input  logic [XLEN-1:0] dresp_data,
    output logic            stall_req,
    output logic            out_valid,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic [XLEN-1:0] out_wdata,
    output logic            out_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t          state_reg, state_next;

    // Instruction fields captured at accept; they stay stable for the whole access.
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [1:0]      size_reg;
    logic [4:0]      rd_reg;
    logic            wen_reg;
    logic            unsigned_reg;
    logic            store_reg;
    logic            drop_reg;

    logic            out_valid_reg;
    logic [4:0]      out_rd_reg;
    logic            out_wen_reg;
    logic [XLEN-1:0] out_wdata_reg;
    logic            out_misalign_reg;

    logic            accept;
    logic            is_mem;
    logic            misalign_hit;
    logic            mem_done;
    logic [7:0]      strobe_base;
    logic [XLEN-1:0] load_raw;
    logic [XLEN-1:0] load_ext;

    assign is_mem = in_is_load | in_is_store;
    assign accept = ((state_reg == IDLE) || (state_reg == RESP)) && in_valid && !flush;

    // Access completes on data_ok; data_ok seen in REQ before addr_ok does not count.
    assign mem_done = ((state_reg == REQ) && dresp_addr_ok && dresp_data_ok) ||
                      ((state_reg == WAIT) && dresp_data_ok);

`ifdef MEM_MISALIGN_CHECK_EN
    // Natural alignment check on the incoming mem op.
    always_comb begin
        misalign_hit = 1'b0;
        if (is_mem) begin
            case (in_size)
                2'd1:    misalign_hit = in_addr[0];
                2'd2:    misalign_hit = |in_addr[1:0];
                2'd3:    misalign_hit = |in_addr[2:0];
                default: misalign_hit = 1'b0;
            endcase
        end
    end
`else
    assign misalign_hit = 1'b0;
`endif

    // Next-state logic for the bus handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, RESP: begin
                if (accept && is_mem && !misalign_hit)
                    state_next = REQ;
                else
                    state_next = IDLE;
            end
            REQ: begin
                if (dresp_addr_ok)
                    state_next = dresp_data_ok ? RESP : WAIT;
            end
            WAIT: begin
                if (dresp_data_ok)
                    state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Capture the mem op on accept; track a flush that arrives mid-access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg     <= '0;
            wdata_reg    <= '0;
            size_reg     <= '0;
            rd_reg       <= '0;
            wen_reg      <= 1'b0;
            unsigned_reg <= 1'b0;
            store_reg    <= 1'b0;
            drop_reg     <= 1'b0;
        end else begin
            if (accept && is_mem && !misalign_hit) begin
                addr_reg     <= in_addr;
                wdata_reg    <= in_wdata;
                size_reg     <= in_size;
                rd_reg       <= in_rd;
                wen_reg      <= in_wen;
                unsigned_reg <= in_unsigned;
                store_reg    <= in_is_store;
            end
            if (state_reg == RESP)
                drop_reg <= 1'b0;
            else if (((state_reg == REQ) || (state_reg == WAIT)) && flush)
                drop_reg <= 1'b1;
        end
    end

    // Bus request fields derived from the latched op; lanes beyond byte 7 are lost.
    always_comb begin
        case (size_reg)
            2'd0:    strobe_base = 8'h01;
            2'd1:    strobe_base = 8'h03;
            2'd2:    strobe_base = 8'h0F;
            default: strobe_base = 8'hFF;
        endcase
    end

    assign dreq_valid  = (state_reg == REQ);
    assign dreq_addr   = addr_reg;
    assign dreq_size   = size_reg;
    assign dreq_strobe = store_reg ? (strobe_base << addr_reg[2:0]) : 8'h00;
    assign dreq_data   = store_reg ? (wdata_reg << {addr_reg[2:0], 3'b000}) : '0;
    assign stall_req   = (state_reg == REQ) || (state_reg == WAIT);

    // Load alignment and sign/zero extension of the returned bus word.
    always_comb begin
        load_raw = dresp_data >> {addr_reg[2:0], 3'b000};
        case (size_reg)
            2'd0: load_ext = unsigned_reg ? {{(XLEN-8){1'b0}}, load_raw[7:0]}
                                          : {{(XLEN-8){load_raw[7]}}, load_raw[7:0]};
            2'd1: load_ext = unsigned_reg ? {{(XLEN-16){1'b0}}, load_raw[15:0]}
                                          : {{(XLEN-16){load_raw[15]}}, load_raw[15:0]};
            2'd2: load_ext = unsigned_reg ? {{(XLEN-32){1'b0}}, load_raw[31:0]}
                                          : {{(XLEN-32){load_raw[31]}}, load_raw[31:0]};
            default: load_ext = load_raw;
        endcase
    end

    // Registered writeback record: pulses for one cycle per instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg    <= 1'b0;
            out_rd_reg       <= '0;
            out_wen_reg      <= 1'b0;
            out_wdata_reg    <= '0;
            out_misalign_reg <= 1'b0;
        end else begin
            out_valid_reg    <= 1'b0;
            out_misalign_reg <= 1'b0;
            if (accept && !is_mem) begin
                out_valid_reg <= 1'b1;
                out_rd_reg    <= in_rd;
                out_wen_reg   <= in_wen;
                out_wdata_reg <= in_result;
            end else if (accept && misalign_hit) begin
                out_valid_reg    <= 1'b1;
                out_misalign_reg <= 1'b1;
                out_rd_reg       <= in_rd;
                out_wen_reg      <= 1'b0;
                out_wdata_reg    <= in_addr;
            end else if (mem_done) begin
                // A flush seen in the completion cycle squashes the record too.
                out_valid_reg <= !(drop_reg || flush);
                out_rd_reg    <= rd_reg;
                out_wen_reg   <= wen_reg && !store_reg && !(drop_reg || flush);
                out_wdata_reg <= store_reg ? '0 : load_ext;
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_rd       = out_rd_reg;
    assign out_wen      = out_wen_reg;
    assign out_wdata    = out_wdata_reg;
    assign out_misalign = out_misalign_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed cases plus randomized load/store/ALU traffic
// checked against a byte-level reference model of the memory stage rules.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid, in_is_load, in_is_store, in_unsigned, in_wen;
    logic [1:0]  in_size;
    logic [63:0] in_addr, in_wdata, in_result;
    logic [4:0]  in_rd;
    logic        dreq_valid;
    logic [63:0] dreq_addr, dreq_data;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        stall_req, out_valid, out_wen, out_misalign;
    logic [4:0]  out_rd;
    logic [63:0] out_wdata;

    int errors = 0;
    int checks = 0;

    mem_stage #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_result(in_result), .in_rd(in_rd), .in_wen(in_wen),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .stall_req(stall_req), .out_valid(out_valid), .out_rd(out_rd), .out_wen(out_wen),
        .out_wdata(out_wdata), .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte b of the bus is written when it lies inside [off, off+nbytes).
    function automatic logic [7:0] ref_strobe(input logic [63:0] addr, input logic [1:0] sz);
        int off = int'(addr[2:0]);
        int n = 1 << sz;
        logic [7:0] s = 8'h00;
        for (int b = 0; b < 8; b++)
            if (b >= off && b < off + n) s[b] = 1'b1;
        return s;
    endfunction

    // Reference: bus byte b carries store byte b-off; lower lanes are zero.
    function automatic logic [63:0] ref_sdata(input logic [63:0] addr, input logic [63:0] wd);
        int off = int'(addr[2:0]);
        logic [63:0] d = 64'd0;
        for (int b = 0; b < 8; b++)
            if (b >= off) d[8*b +: 8] = wd[8*(b-off) +: 8];
        return d;
    endfunction

    // Reference: collect bytes off.. from the bus word, then extend from the top bit.
    function automatic logic [63:0] ref_load(input logic [63:0] raw, input logic [63:0] addr,
                                             input logic [1:0] sz, input bit uns);
        int off = int'(addr[2:0]);
        int n = 1 << sz;
        logic [63:0] v = 64'd0;
        bit neg;
        for (int b = 0; b < n; b++)
            if (off + b < 8) v[8*b +: 8] = raw[8*(off+b) +: 8];
        neg = v[8*n-1];
        if (!uns && neg)
            for (int b = n; b < 8; b++) v[8*b +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic do_alu(input logic [63:0] res, input logic [4:0] rd, input bit wen, input bit fl);
        in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b0;
        in_result = res; in_rd = rd; in_wen = wen; flush = fl;
        in_addr = {$urandom, $urandom};
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        $display("alu res=%h rd=%0d flush=%0d -> out_valid=%0d out_wdata=%h", res, rd, fl, out_valid, out_wdata);
        chk("alu_stall", {63'd0, stall_req}, 64'd0);
        chk("alu_out_valid", {63'd0, out_valid}, {63'd0, !fl});
        if (!fl) begin
            chk("alu_wdata", out_wdata, res);
            chk("alu_rd", {59'd0, out_rd}, {59'd0, rd});
            chk("alu_wen", {63'd0, out_wen}, {63'd0, wen});
        end
    endtask

    // One load/store: addr_ok arrives a_dly cycles into REQ, data_ok d_dly cycles later.
    task automatic do_mem(input bit ld, input logic [1:0] sz, input bit uns,
                          input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rdata,
                          input logic [4:0] rd, input int a_dly, input int d_dly, input int flush_at);
        int cyc = 0;
        int stalls = 0;
        bit drop = 1'b0;
        in_valid = 1'b1; in_is_load = ld; in_is_store = !ld; in_size = sz; in_unsigned = uns;
        in_addr = addr; in_wdata = wd; in_result = {$urandom, $urandom}; in_rd = rd; in_wen = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("req_addr", dreq_addr, addr);
        chk("req_size", {62'd0, dreq_size}, {62'd0, sz});
        chk("req_strobe", {56'd0, dreq_strobe}, ld ? 64'd0 : {56'd0, ref_strobe(addr, sz)});
        if (!ld) chk("req_data", dreq_data, ref_sdata(addr, wd));
        for (int k = 0; k <= a_dly; k++) begin
            chk("req_valid", {63'd0, dreq_valid}, 64'd1);
            if (stall_req) stalls++;
            dresp_addr_ok = (k == a_dly);
            if (k == a_dly) begin
                dresp_data_ok = (d_dly == 0);
                dresp_data = (d_dly == 0) ? rdata : {$urandom, $urandom};
            end else begin
                dresp_data_ok = 1'($urandom_range(0, 1));
                dresp_data = {$urandom, $urandom};
            end
            flush = (cyc == flush_at);
            if (flush) drop = 1'b1;
            cyc++;
            @(posedge clk); @(negedge clk);
            dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; flush = 1'b0;
        end
        for (int j = 1; j <= d_dly; j++) begin
            chk("wait_req_valid", {63'd0, dreq_valid}, 64'd0);
            if (stall_req) stalls++;
            dresp_data_ok = (j == d_dly);
            dresp_data = (j == d_dly) ? rdata : {$urandom, $urandom};
            flush = (cyc == flush_at);
            if (flush) drop = 1'b1;
            cyc++;
            @(posedge clk); @(negedge clk);
            dresp_data_ok = 1'b0; flush = 1'b0;
        end
        $display("mem ld=%0d sz=%0d addr=%h a=%0d d=%0d drop=%0d -> out_valid=%0d out_wdata=%h stalls=%0d",
                 ld, sz, addr, a_dly, d_dly, drop, out_valid, out_wdata, stalls);
        chk("resp_stall", {63'd0, stall_req}, 64'd0);
        chk("stall_cycles", 64'(stalls), 64'(a_dly + 1 + d_dly));
        chk("resp_out_valid", {63'd0, out_valid}, {63'd0, !drop});
        if (!drop) begin
            chk("resp_wen", {63'd0, out_wen}, {63'd0, ld});
            chk("resp_rd", {59'd0, out_rd}, {59'd0, rd});
            if (ld) chk("resp_load", out_wdata, ref_load(rdata, addr, sz, uns));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [1:0]  sz;
        int ad, dd;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_size = 2'd0; in_unsigned = 1'b0; in_addr = '0; in_wdata = '0; in_result = '0;
        in_rd = '0; in_wen = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
        repeat (2) @(negedge clk);
        $display("reset: dreq_valid=%0d stall=%0d out_valid=%0d", dreq_valid, stall_req, out_valid);
        chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("rst_stall", {63'd0, stall_req}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_wdata", out_wdata, 64'd0);
        chk("rst_strobe", {56'd0, dreq_strobe}, 64'd0);
        chk("rst_misalign", {63'd0, out_misalign}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // ALU pass-through
        do_alu(64'h1234, 5'd5, 1'b1, 1'b0);
        // lb sign-extended, completed in the REQ cycle
        do_mem(1'b1, 2'd0, 1'b0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 5'd7, 0, 0, -1);
        chk("lb_value", out_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        // sw with addr_ok at +3, data_ok at +6
        do_mem(1'b0, 2'd2, 1'b0, 64'h1004, 64'hDEAD_BEEF, 64'h0, 5'd9, 2, 3, -1);
        chk("sw_strobe_const", {56'd0, dreq_strobe}, 64'h00F0);
        chk("sw_data_const", dreq_data, 64'hDEAD_BEEF_0000_0000);
        // lhu flushed during WAIT, then ALU accepted in the RESP cycle
        do_mem(1'b1, 2'd1, 1'b1, 64'h2002, 64'h0, {$urandom, $urandom}, 5'd3, 1, 2, 2);
        do_alu(64'hA5A5, 5'd11, 1'b1, 1'b0);
        // flushed ALU op produces nothing
        do_alu(64'h7777, 5'd12, 1'b1, 1'b1);

        // Asynchronous reset while waiting for data
        in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_size = 2'd3; in_addr = 64'h40; in_rd = 5'd4;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; dresp_addr_ok = 1'b1;
        @(posedge clk); @(negedge clk);
        dresp_addr_ok = 1'b0;
        chk("wait_stall", {63'd0, stall_req}, 64'd1);
        #2 reset = 1'b1;
        #1;
        $display("async reset in WAIT: dreq_valid=%0d stall=%0d out_valid=%0d", dreq_valid, stall_req, out_valid);
        chk("arst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("arst_stall", {63'd0, stall_req}, 64'd0);
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

`ifdef MEM_MISALIGN_CHECK_EN
        in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_size = 2'd2; in_addr = 64'h3002; in_rd = 5'd6; in_wen = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        $display("misaligned lw: dreq_valid=%0d out_valid=%0d out_misalign=%0d", dreq_valid, out_valid, out_misalign);
        chk("mis_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("mis_out_valid", {63'd0, out_valid}, 64'd1);
        chk("mis_flag", {63'd0, out_misalign}, 64'd1);
        chk("mis_wen", {63'd0, out_wen}, 64'd0);
        @(negedge clk);
`endif

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            a  = {$urandom, $urandom};
            sz = 2'($urandom_range(0, 3));
            ad = int'($urandom_range(0, 3));
            dd = int'($urandom_range(0, 3));
`ifdef MEM_MISALIGN_CHECK_EN
            a = a & ~((64'd1 << sz) - 64'd1);
`endif
            do_mem(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                   {$urandom, $urandom}, 5'($urandom_range(0, 31)), ad, dd,
                   int'($urandom_range(0, ad + dd + 3)));
            if ($urandom_range(0, 1) == 1)
                do_alu({$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
